// File: rtl/uart_sample_packer_if.sv
// Byte-FIFO and sample/result handshake bundle around uart_sample_packer.
// master is the packer side; slave is the FIFO/algorithm side.
interface uart_sample_packer_if;
    logic        rx_fifo_empty;
    logic [7:0]  rx_fifo_dout;
    logic        rx_fifo_rd;
    logic [10:0] smp_data;
    logic        smp_vld;
    logic        smp_rdy;
    logic [10:0] res_data;
    logic        res_vld;
    logic        res_rdy;
    logic        tx_fifo_full;
    logic [7:0]  tx_fifo_din;
    logic        tx_fifo_wr;

    modport master (
        input  rx_fifo_empty, rx_fifo_dout, smp_rdy, res_data, res_vld, tx_fifo_full,
        output rx_fifo_rd, smp_data, smp_vld, res_rdy, tx_fifo_din, tx_fifo_wr
    );

    modport slave (
        output rx_fifo_empty, rx_fifo_dout, smp_rdy, res_data, res_vld, tx_fifo_full,
        input  rx_fifo_rd, smp_data, smp_vld, res_rdy, tx_fifo_din, tx_fifo_wr
    );
endinterface

// File: rtl/uart_sample_packer.sv
// Packs RX byte pairs into 11-bit samples (valid 2 cycles after low pop) and splits results into TX byte pairs (1-2 cycles after accept).
// smp_rdy, tx_fifo_full and en stall each path in place; frame and timeout errors are sticky until reset.
module uart_sample_packer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst,
    input  logic                 en,
    uart_sample_packer_if.master bus,
    output logic                 err_frame,
    output logic                 err_timeout,
    output logic                 busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_LOW, RX_HIGH, RX_OUT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH} tx_state_t;

    rx_state_t     rx_q, rx_d;
    tx_state_t     tx_q, tx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    lo_q, lo_d;
    logic [10:0]   smp_q, smp_d;
    logic [10:0]   res_q, res_d;
    logic          err_frame_q, err_frame_d;
    logic          err_timeout_q, err_timeout_d;
    logic          clr, rx_pop, tx_push;
    logic          rx_rd, tx_wr, tx_rdy;
    logic [7:0]    tx_din;

    // Reset also gates the strobes so a reset edge never consumes or emits a byte.
    assign clr     = rst | sw_rst;
    assign rx_pop  = en & ~bus.rx_fifo_empty & ~clr;
    assign tx_push = en & ~bus.tx_fifo_full & ~clr;

    always_comb begin
        rx_d          = rx_q;
        timer_d       = timer_q;
        lo_d          = lo_q;
        smp_d         = smp_q;
        err_frame_d   = err_frame_q;
        err_timeout_d = err_timeout_q;
        rx_rd         = 1'b0;
        case (rx_q)
            RX_LOW: begin
                if (rx_pop) begin
                    rx_rd   = 1'b1;
                    lo_d    = bus.rx_fifo_dout;
                    timer_d = '0;
                    rx_d    = RX_HIGH;
                end
            end
            RX_HIGH: begin
                if (rx_pop) begin
                    rx_rd = 1'b1;
                    if (bus.rx_fifo_dout[7:3] == 5'd0) begin
                        smp_d = {bus.rx_fifo_dout[2:0], lo_q};
                        rx_d  = RX_OUT;
                    end else begin
                        err_frame_d = 1'b1;
                        rx_d        = RX_LOW;
                    end
                end else if (en) begin
                    // A byte arriving in the T_LAST cycle wins over the timeout.
                    if (timer_q == T_LAST) begin
                        err_timeout_d = 1'b1;
                        rx_d          = RX_LOW;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            RX_OUT: begin
                if (bus.smp_rdy) rx_d = RX_LOW;
            end
            default: rx_d = RX_LOW;
        endcase
    end

    always_comb begin
        tx_d   = tx_q;
        res_d  = res_q;
        tx_wr  = 1'b0;
        tx_din = 8'h00;
        tx_rdy = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                tx_rdy = en & ~clr;
                if (tx_rdy && bus.res_vld) begin
                    res_d = bus.res_data;
                    tx_d  = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tx_push) begin
                    tx_wr  = 1'b1;
                    tx_din = res_q[7:0];
                    tx_d   = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (tx_push) begin
                    tx_wr  = 1'b1;
                    tx_din = {5'b00000, res_q[10:8]};
                    tx_d   = TX_IDLE;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_q          <= RX_LOW;
            tx_q          <= TX_IDLE;
            timer_q       <= '0;
            lo_q          <= 8'h00;
            smp_q         <= 11'h000;
            res_q         <= 11'h000;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            timer_q       <= timer_d;
            lo_q          <= lo_d;
            smp_q         <= smp_d;
            res_q         <= res_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.rx_fifo_rd  = rx_rd;
    assign bus.smp_vld     = (rx_q == RX_OUT);
    assign bus.smp_data    = smp_q;
    assign bus.res_rdy     = tx_rdy;
    assign bus.tx_fifo_wr  = tx_wr;
    assign bus.tx_fifo_din = tx_din;
    assign err_frame       = err_frame_q;
    assign err_timeout     = err_timeout_q;
    assign busy            = (rx_q != RX_LOW) | (tx_q != TX_IDLE);
endmodule
